// File: rtl/adc_sar_pkg.sv
// adc_sar_pkg: shared sizes, state encoding and bit-mask helper for the SAR sequencer
package adc_sar_pkg;
    localparam int N_BITS       = 10;
    localparam int AVG_MAX_LOG2 = 7;
    localparam int ACC_W        = N_BITS + AVG_MAX_LOG2;
    localparam int K_W          = $clog2(N_BITS);
    localparam int CNT_W        = AVG_MAX_LOG2 + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SAMPLE,
        S_TRIAL,
        S_WAIT,
        S_NEXT,
        S_DONE
    } state_t;

    function automatic logic [N_BITS-1:0] bit_mask(input logic [K_W-1:0] k);
        return {{(N_BITS-1){1'b0}}, 1'b1} << k;
    endfunction
endpackage

// File: rtl/adc_sar_accumulator.sv
// adc_sar_accumulator: conversion sum with clear/add and a shifted (averaged) view of the next sum
module adc_sar_accumulator
    import adc_sar_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clr,
    input  logic              i_add,
    input  logic [N_BITS-1:0] i_din,
    input  logic [2:0]        i_shift,
    output logic [N_BITS-1:0] o_avg
);
    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] w_nxt;

    // o_avg looks at the post-add value so the final sum is usable on the same edge it lands
    always_comb begin
        w_nxt = i_clr ? '0 : i_add ? r_acc + ACC_W'(i_din) : r_acc;
        o_avg = N_BITS'(w_nxt >> i_shift);
    end

    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) r_acc <= '0;
        else          r_acc <= w_nxt;
endmodule

// File: rtl/adc_sar_sequencer.sv
// adc_sar_sequencer: sample phase, MSB-first binary search and power-of-two averaging for the SAR ADC
module adc_sar_sequencer
    import adc_sar_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_enable,
    input  logic              i_start,
    input  logic [3:0]        i_sample_cycles,
    input  logic [2:0]        i_avg_log2,
    input  logic              i_comp_valid,
    input  logic              i_comp_out,
    output logic [N_BITS-1:0] o_dac_code,
    output logic              o_sample_n,
    output logic              o_comp_trig,
    output logic              o_busy,
    output logic [N_BITS-1:0] o_result,
    output logic              o_result_valid,
    input  logic              i_result_ready
);
    state_t            r_state, w_next;
    logic [3:0]        r_smp, r_phase;
    logic [2:0]        r_avg;
    logic [K_W-1:0]    r_k, w_k_nxt;
    logic [N_BITS-1:0] r_partial, w_part_nxt, w_dac, w_avg;
    logic [CNT_W-1:0]  r_cnt;
    logic              w_last, w_clr, w_add;

    adc_sar_accumulator u_acc (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (w_clr),
        .i_add   (w_add),
        .i_din   (r_partial),
        .i_shift (r_avg),
        .o_avg   (w_avg)
    );

    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;

    always_comb begin
        w_last = (r_cnt + CNT_W'(1)) == (CNT_W'(1) << r_avg);
        w_next = r_state;
        if (!i_enable)
            w_next = S_IDLE;
        else
            case (r_state)
                S_IDLE:   w_next = i_start ? S_SAMPLE : S_IDLE;
                S_SAMPLE: w_next = r_phase == '0 ? S_TRIAL : S_SAMPLE;
                S_TRIAL:  w_next = S_WAIT;
                S_WAIT:   w_next = i_comp_valid ? S_NEXT : S_WAIT;
                S_NEXT:   w_next = r_k != '0 ? S_TRIAL : w_last ? S_DONE : S_SAMPLE;
                S_DONE:   w_next = i_result_ready ? S_IDLE : S_DONE;
                default:  w_next = S_IDLE;
            endcase
    end

    // outputs are computed from the next state and registered, so they are valid in the state they describe
    always_comb begin
        w_clr      = r_state == S_IDLE && w_next == S_SAMPLE;
        w_add      = r_state == S_NEXT && r_k == '0 && i_enable;
        w_k_nxt    = r_state == S_SAMPLE ? K_W'(N_BITS - 1) : r_k - K_W'(1);
        w_part_nxt = r_state == S_SAMPLE ? '0 : r_partial;
        w_dac      = w_next == S_TRIAL ? (w_part_nxt | bit_mask(w_k_nxt))
                   : (w_next == S_WAIT || w_next == S_NEXT) ? o_dac_code : '0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) begin
            r_smp          <= '0;
            r_avg          <= '0;
            r_cnt          <= '0;
            r_phase        <= '0;
            r_k            <= '0;
            r_partial      <= '0;
            o_dac_code     <= '0;
            o_sample_n     <= 1'b1;
            o_comp_trig    <= 1'b0;
            o_busy         <= 1'b0;
            o_result       <= '0;
            o_result_valid <= 1'b0;
        end else begin
            if (w_clr) begin
                r_smp <= i_sample_cycles;
                r_avg <= i_avg_log2;
                r_cnt <= '0;
            end else if (w_add)
                r_cnt <= r_cnt + CNT_W'(1);
            if (w_next == S_SAMPLE && r_state != S_SAMPLE)
                r_phase <= w_clr ? i_sample_cycles : r_smp;
            else if (r_state == S_SAMPLE)
                r_phase <= r_phase - 4'd1;
            if (w_next == S_TRIAL) begin
                r_k       <= w_k_nxt;
                r_partial <= w_part_nxt;
            end else if (r_state == S_WAIT && w_next == S_NEXT)
                r_partial[r_k] <= i_comp_out;
            o_dac_code     <= w_dac;
            o_sample_n     <= w_next != S_SAMPLE;
            o_comp_trig    <= w_next == S_TRIAL;
            o_busy         <= w_next != S_IDLE;
            o_result_valid <= w_next == S_DONE;
            if (r_state == S_NEXT && w_next == S_DONE)
                o_result <= w_avg;
        end
endmodule

// File: tb/tb_adc_sar_sequencer.sv
// tb_adc_sar_sequencer: directed and randomized conversions against an arithmetic SAR/averaging model
module tb_adc_sar_sequencer;
    import adc_sar_pkg::*;

    logic clk, rst_n, enable, start, result_ready;
    logic comp_valid = 1'b0;
    logic comp_out = 1'b0;
    logic [3:0] sample_cycles;
    logic [2:0] avg_log2;
    logic [N_BITS-1:0] dac_code, result;
    logic sample_n, comp_trig, busy, result_valid;

    int checks = 0, failures = 0;
    logic [N_BITS-1:0] vin_arr [128];
    logic [N_BITS-1:0] trial_log [4096];
    int nvin = 1, samp_base = 0, fix_lat = 1;
    int n_samp = 0, n_trials = 0, lat_total = 0;
    bit spur = 0, hold_chk = 1, prev_sn = 1, seen;
    logic [N_BITS-1:0] code, vin_now, last_res;
    int lat, idx;
    logic [2:0] a;

    adc_sar_sequencer dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_enable        (enable),
        .i_start         (start),
        .i_sample_cycles (sample_cycles),
        .i_avg_log2      (avg_log2),
        .i_comp_valid    (comp_valid),
        .i_comp_out      (comp_out),
        .o_dac_code      (dac_code),
        .o_sample_n      (sample_n),
        .o_comp_trig     (comp_trig),
        .o_busy          (busy),
        .o_result        (result),
        .o_result_valid  (result_valid),
        .i_result_ready  (result_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!sample_n && prev_sn) n_samp++;
        prev_sn = sample_n;
    end

    // comparator: answers each trigger after a fixed or random latency with vin >= trial code
    always begin
        @(negedge clk);
        comp_valid = 1'b0;
        if (comp_trig) begin
            code = dac_code;
            if (n_trials < 4096) trial_log[n_trials] = code;
            n_trials++;
            lat = fix_lat != 0 ? fix_lat : int'($urandom_range(1, 5));
            lat_total += lat;
            idx = n_samp - samp_base - 1;
            vin_now = (idx >= 0 && idx < 128) ? vin_arr[idx] : '0;
            repeat (lat) begin
                @(negedge clk);
                if (hold_chk) check("dac_hold", 32'(dac_code), 32'(code));
            end
            comp_out = vin_now >= code;
            comp_valid = 1'b1;
        end else if (spur && !sample_n) begin
            comp_valid = 1'($urandom_range(0, 1));
            comp_out = 1'($urandom_range(0, 1));
        end
    end

    task automatic run(input logic [3:0] sc, input logic [2:0] avg, input int lt, input bit sp,
                       input int hold, input bit poke);
        int t, lat0, tr0;
        logic [ACC_W-1:0] sum;
        logic [N_BITS-1:0] exp_res, p, tc;
        fix_lat = lt;
        spur = sp;
        nvin = 1 << avg;
        sum = '0;
        for (int i = 0; i < nvin; i++) sum += ACC_W'(vin_arr[i]);
        exp_res = N_BITS'(sum >> avg);
        samp_base = n_samp;
        lat0 = lat_total;
        tr0 = n_trials;
        sample_cycles = sc;
        avg_log2 = avg;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t = 0;
        while (!result_valid && t < 5000) begin
            @(negedge clk);
            t++;
            start = poke && t == 5;
        end
        start = 1'b0;
        check("cycles", 32'(t), 32'(nvin * (int'(sc) + 1) + lat_total - lat0 + 2 * (n_trials - tr0)));
        check("trials", 32'(n_trials - tr0), 32'(N_BITS * nvin));
        check("samples", 32'(n_samp - samp_base), 32'(nvin));
        check("result", 32'(result), 32'(exp_res));
        check("busy_done", 32'(busy), 32'(1));
        check("done_dac", 32'(dac_code), 32'(0));
        if (nvin == 1) begin
            p = '0;
            for (int i = 0; i < N_BITS; i++) begin
                tc = p | (N_BITS'(1) << (N_BITS - 1 - i));
                check("trial_code", 32'(trial_log[tr0 + i]), 32'(tc));
                if (vin_arr[0] >= tc) p = tc;
            end
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("rv_hold", 32'(result_valid), 32'(1));
            check("busy_hold", 32'(busy), 32'(1));
        end
        result_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
        start = 1'b0;
        check("rv_clear", 32'(result_valid), 32'(0));
        check("busy_clear", 32'(busy), 32'(0));
        check("result_kept", 32'(result), 32'(exp_res));
        @(negedge clk);
        check("no_queued_start", 32'(busy), 32'(0));
        last_res = exp_res;
    endtask

    task automatic kick_until_trig(output bit s);
        sample_cycles = 4'd2;
        avg_log2 = 3'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        s = 1'b0;
        for (int i = 0; i < 200 && !s; i++) begin
            @(negedge clk);
            s = comp_trig;
        end
        check("trig_seen", 32'(s), 32'(1));
    endtask

    initial begin
        rst_n = 1'b1;
        enable = 1'b0;
        start = 1'b0;
        result_ready = 1'b0;
        sample_cycles = '0;
        avg_log2 = '0;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_dac", 32'(dac_code), 32'(0));
        check("rst_sample_n", 32'(sample_n), 32'(1));
        check("rst_trig", 32'(comp_trig), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_result", 32'(result), 32'(0));
        check("rst_rv", 32'(result_valid), 32'(0));
        rst_n = 1'b1;
        enable = 1'b1;
        @(negedge clk);

        vin_arr[0] = 10'h2A5;
        run(4'd3, 3'd0, 1, 1'b0, 10, 1'b1);

        vin_arr[0] = 10'h000;
        run(4'd2, 3'd0, 2, 1'b0, 0, 1'b0);
        vin_arr[0] = 10'h3FF;
        run(4'd0, 3'd0, 1, 1'b0, 0, 1'b0);

        vin_arr[0] = 10'h100;
        vin_arr[1] = 10'h103;
        vin_arr[2] = 10'h101;
        vin_arr[3] = 10'h102;
        run(4'd1, 3'd2, 1, 1'b0, 0, 1'b0);
        check("acc", 32'(dut.u_acc.r_acc), 32'(17'h406));

        for (int r = 0; r < 6; r++) begin
            a = 3'($urandom_range(0, 3));
            for (int i = 0; i < (1 << a); i++) vin_arr[i] = N_BITS'($urandom);
            run(4'($urandom), a, 0, 1'b1, int'($urandom_range(0, 3)), 1'b1);
        end

        spur = 1'b0;
        fix_lat = 5;
        vin_arr[0] = 10'h155;
        samp_base = n_samp;
        hold_chk = 1'b0;
        kick_until_trig(seen);
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'(0));
        check("abort_dac", 32'(dac_code), 32'(0));
        check("abort_sample_n", 32'(sample_n), 32'(1));
        check("abort_rv", 32'(result_valid), 32'(0));
        check("abort_result", 32'(result), 32'(last_res));
        enable = 1'b1;
        repeat (8) @(negedge clk);

        kick_until_trig(seen);
        check("trial_dac", 32'(dac_code), 32'(10'h200));
        #1 rst_n = 1'b0;
        #1;
        check("arst_dac", 32'(dac_code), 32'(0));
        check("arst_sample_n", 32'(sample_n), 32'(1));
        check("arst_trig", 32'(comp_trig), 32'(0));
        check("arst_busy", 32'(busy), 32'(0));
        check("arst_result", 32'(result), 32'(0));
        check("arst_rv", 32'(result_valid), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
